// File: rtl/demux_1x8_deser_pkg.sv
// demux_1x8_deser_pkg: shared frame constants and FSM encoding
package demux_1x8_deser_pkg;
  localparam int SLOTS = 8;
  localparam int SEL_W = 3;
  typedef enum logic {ST_HUNT = 1'b0, ST_COLLECT = 1'b1} state_t;
endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: mod-SLOTS slot counter with clear, load-to-1 and enable
// clk, rst_n: clock and sync active-low reset; clr_i > load1_i > en_i
// cnt_o: current slot; term_o: cnt_o == SLOTS-1
module demux_slot_ctr
  import demux_1x8_deser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             term_o
);
  logic [SEL_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : load1_i ? SEL_W'(1) : en_i ? cnt_q + SEL_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign cnt_o  = cnt_q;
  assign term_o = cnt_q == SEL_W'(SLOTS - 1);
endmodule

// File: rtl/demux_1x8_deser.sv
// demux_1x8_deser: 1-to-8 serial deserialiser with valid/ready frame output
// in:  clk, rst_n (sync active-low), din, din_valid, frame_start, dout_ready
// out: dout/dout_valid (held frame), slot (next slot), sync_err, overrun pulses
module demux_1x8_deser
  import demux_1x8_deser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SLOTS-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] slot,
  output logic             sync_err,
  output logic             overrun
);
  state_t           state_q, state_d;
  logic [SLOTS-2:0] work_q, work_d;
  logic [SLOTS-1:0] dout_q, dout_d;
  logic             dv_q, dv_d, sync_err_q, sync_err_d, overrun_q, overrun_d;
  logic             en, term, complete, accept;
  // frame_start overrides accumulation; HUNT ignores plain valid bits
  assign en       = state_q == ST_COLLECT && din_valid && !frame_start;
  assign complete = en && term;
  assign accept   = complete && (!dv_q || dout_ready);
  demux_slot_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (frame_start && !din_valid),
    .load1_i(frame_start && din_valid),
    .en_i   (en),
    .cnt_o  (slot),
    .term_o (term)
  );
  // the last bit of a frame goes straight to dout, so work holds slots 0..SLOTS-2
  always_comb begin
    work_d = work_q;
    if (frame_start) work_d = {{(SLOTS - 2){1'b0}}, din & din_valid};
    else if (en && !term) work_d[slot] = din;
  end
  always_comb begin
    state_d    = frame_start ? ST_COLLECT : state_q;
    dout_d     = accept ? {din, work_q} : dout_q;
    dv_d       = accept || (dv_q && !dout_ready);
    sync_err_d = state_q == ST_COLLECT && frame_start && slot != '0;
    overrun_d  = complete && dv_q && !dout_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      work_q     <= '0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      sync_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      sync_err_q <= sync_err_d;
      overrun_q  <= overrun_d;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_demux_1x8_deser.sv
// tb_demux_1x8_deser: table-driven and scoreboard checks for demux_1x8_deser
module tb_demux_1x8_deser;
  logic       clk = 1'b0;
  logic       rst_n, din, din_valid, frame_start, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, sync_err, overrun;
  logic [2:0] slot;
  int         checks = 0;
  int         passed = 0;
  logic [7:0] sb[$];
  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];
  demux_1x8_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .slot       (slot),
    .sync_err   (sync_err),
    .overrun    (overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk)
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) check("sb_unexpected_frame", {24'd0, dout}, 32'hFFFF_FFFF);
      else check("sb_dout", {24'd0, dout}, {24'd0, sb.pop_front()});
    end
  task automatic step(input logic fs, input logic dv, input logic d);
    frame_start = fs;
    din_valid   = dv;
    din         = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask
  task automatic partial(input int n, input logic d);
    for (int k = 0; k < n; k++) step(k == 0, 1'b1, d);
  endtask
  task automatic send_frame(input logic [7:0] dval, input bit push, input logic exp_se,
                            input logic rdy_last);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        dout_ready = rdy_last;
        if (push) sb.push_back(dval);
      end
      step(k == 0, 1'b1, dval[k]);
      if (k == 0) check("sync_err_start", {31'd0, sync_err}, {31'd0, exp_se});
      if (k == 1) check("sync_err_clear", {31'd0, sync_err}, 32'd0);
    end
  endtask
  initial begin
    tbl[0] = '{8'b10110010, 8'h4D};
    tbl[1] = '{8'hFF, 8'hFF};
    tbl[2] = '{8'h00, 8'h00};
    tbl[3] = '{8'b10100101, 8'hA5};
    tbl[4] = '{8'b00000001, 8'h80};
    tbl[5] = '{8'b11000000, 8'h03};
    tbl[6] = '{8'b01101000, 8'h16};
    tbl[7] = '{8'b00111100, 8'h3C};
    rst_n = 1'b0; dout_ready = 1'b0;
    idle(); idle();
    rst_n = 1'b1;
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_slot", {29'd0, slot}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);
    check("hunt_slot", {29'd0, slot}, 32'd0);
    check("hunt_dout_valid", {31'd0, dout_valid}, 32'd0);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] dval;
      for (int k = 0; k < 8; k++) dval[k] = tbl[i].seq[7-k];
      send_frame(dval, 1'b1, 1'b0, 1'b1);
      check("tbl_dout", {24'd0, dout}, {24'd0, tbl[i].exp});
      check("tbl_dout_valid", {31'd0, dout_valid}, 32'd1);
      check("tbl_slot", {29'd0, slot}, 32'd0);
    end
    idle();
    check("drain_dout_valid", {31'd0, dout_valid}, 32'd0);
    partial(5, 1'b0);
    check("partial_slot", {29'd0, slot}, 32'd5);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    check("slip_dout", {24'd0, dout}, 32'hFF);
    idle();
    partial(5, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    check("slip_no_leak", {24'd0, dout}, 32'h00);
    idle();
    dout_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("ovr_a_valid", {31'd0, dout_valid}, 32'd1);
    check("ovr_no_pulse_a", {31'd0, overrun}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    check("ovr_dout_held", {24'd0, dout}, 32'hA5);
    idle();
    check("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    dout_ready = 1'b1;
    idle();
    check("ovr_drop_valid", {31'd0, dout_valid}, 32'd0);
    check("ovr_dout_kept", {24'd0, dout}, 32'hA5);
    dout_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("same_edge_dout", {24'd0, dout}, 32'h3C);
    check("same_edge_valid", {31'd0, dout_valid}, 32'd1);
    check("same_edge_no_ovr", {31'd0, overrun}, 32'd0);
    idle();
    dout_ready = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    partial(4, 1'b1);
    check("pre_rst_slot", {29'd0, slot}, 32'd4);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    check("mid_rst_dout", {24'd0, dout}, 32'd0);
    check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_slot", {29'd0, slot}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("mid_rst_hunt", {29'd0, slot}, 32'd0);
    dout_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    check("post_rst_dout", {24'd0, dout}, 32'h5A);
    idle();
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
